immediate_load_sequencer: RTL and testbench

Sequences immediate-load instructions through the sign/zero-extension constant unit and writes the 8-bit result into the register file.
- Accepts 16-bit instruction words over a valid/ready handshake.
- Drives CS and ImmediateData to the constant unit and captures its extended output.
- Requests a register-file write port through a request/grant handshake with a timeout.
- Supports a high-bits prefix instruction for building full 8-bit constants.

---
 rtl/immediate_load_sequencer.sv | 147 ++++++++++++++
 tb/tb_immediate_load_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_load_sequencer.sv
// Immediate-load sequencer: decodes LDI/LDIS/LDIH, drives the constant unit,
// then writes the extended value to the register file under a grant timeout.
module immediate_load_sequencer #(
    parameter int GRANT_TIMEOUT = 8,
    parameter int COUNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               InstrValid,
    output logic               InstrReady,
    input  logic [15:0]        Instr,
    output logic               CS,
    output logic [5:0]         ImmediateData,
    input  logic [7:0]         ExtIn,
    output logic               RegWrReq,
    input  logic               RegWrGnt,
    output logic [2:0]         RegWrAddr,
    output logic [7:0]         RegWrData,
    output logic               Busy,
    output logic               IllegalOp,
    output logic               WrTimeout,
    output logic [COUNT_W-1:0] LoadCount
);

    localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDIS = 4'h2;
    localparam logic [3:0] OP_LDIH = 4'h3;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_WB} state_t;

    state_t             state_q;
    logic [2:0]         rd_q;
    logic               pfx_vld_q;
    logic [1:0]         pfx_q;
    logic               lat_pfx_vld_q;
    logic [1:0]         lat_pfx_q;
    logic [TW-1:0]      tmo_q;
    logic               ready_q;
    logic               busy_q;
    logic               cs_q;
    logic [5:0]         immd_q;
    logic               req_q;
    logic [2:0]         addr_q;
    logic [7:0]         data_q;
    logic               illegal_q;
    logic               wrto_q;
    logic [COUNT_W-1:0] cnt_q;

    logic [3:0] opcode;
    logic       tmo_hit;
    logic       unused_bits;

    assign opcode      = Instr[15:12];
    assign unused_bits = ^Instr[8:6];
    assign tmo_hit     = (GRANT_TIMEOUT != 0) && (tmo_q == TW'(GRANT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_q          <= '0;
            pfx_vld_q     <= 1'b0;
            pfx_q         <= '0;
            lat_pfx_vld_q <= 1'b0;
            lat_pfx_q     <= '0;
            tmo_q         <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            cs_q          <= 1'b0;
            immd_q        <= '0;
            req_q         <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            illegal_q     <= 1'b0;
            wrto_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            illegal_q <= 1'b0;
            wrto_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (InstrValid) begin
                        if (opcode == OP_LDI || opcode == OP_LDIS) begin
                            rd_q          <= Instr[11:9];
                            lat_pfx_vld_q <= pfx_vld_q;
                            lat_pfx_q     <= pfx_q;
                            pfx_vld_q     <= 1'b0;
                            cs_q          <= (opcode == OP_LDIS);
                            immd_q        <= Instr[5:0];
                            ready_q       <= 1'b0;
                            busy_q        <= 1'b1;
                            state_q       <= S_EXT;
                        end else if (opcode == OP_LDIH) begin
                            pfx_q     <= Instr[1:0];
                            pfx_vld_q <= 1'b1;
                        end else begin
                            illegal_q <= 1'b1;
                            pfx_vld_q <= 1'b0;
                        end
                    end
                end
                S_EXT: begin
                    // The prefix supplies the top two bits and overrides the extension.
                    data_q  <= lat_pfx_vld_q ? {lat_pfx_q, ExtIn[5:0]} : ExtIn;
                    addr_q  <= rd_q;
                    req_q   <= 1'b1;
                    cs_q    <= 1'b0;
                    immd_q  <= '0;
                    tmo_q   <= '0;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (RegWrGnt || tmo_hit) begin
                        if (RegWrGnt) cnt_q  <= cnt_q + 1'b1;
                        else          wrto_q <= 1'b1;
                        req_q   <= 1'b0;
                        addr_q  <= '0;
                        data_q  <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign InstrReady    = ready_q;
    assign Busy          = busy_q;
    assign CS            = cs_q;
    assign ImmediateData = immd_q;
    assign RegWrReq      = req_q;
    assign RegWrAddr     = addr_q;
    assign RegWrData     = data_q;
    assign IllegalOp     = illegal_q;
    assign WrTimeout     = wrto_q;
    assign LoadCount     = cnt_q;

endmodule

// File: tb/tb_immediate_load_sequencer.sv
// Self-checking bench for immediate_load_sequencer with a behavioural load model
// and a constant-unit model on ExtIn.
module tb_immediate_load_sequencer;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        InstrValid;
    logic        InstrReady;
    logic [15:0] Instr;
    logic        CS;
    logic [5:0]  ImmediateData;
    logic [7:0]  ExtIn;
    logic        RegWrReq;
    logic        RegWrGnt;
    logic [2:0]  RegWrAddr;
    logic [7:0]  RegWrData;
    logic        Busy;
    logic        IllegalOp;
    logic        WrTimeout;
    logic [7:0]  LoadCount;

    immediate_load_sequencer #(.GRANT_TIMEOUT(TMO), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instr(Instr), .CS(CS), .ImmediateData(ImmediateData), .ExtIn(ExtIn),
        .RegWrReq(RegWrReq), .RegWrGnt(RegWrGnt), .RegWrAddr(RegWrAddr),
        .RegWrData(RegWrData), .Busy(Busy), .IllegalOp(IllegalOp),
        .WrTimeout(WrTimeout), .LoadCount(LoadCount)
    );

    always #5 clk = ~clk;

    // Constant unit: sign- or zero-extend the 6-bit immediate.
    assign ExtIn = CS ? {{2{ImmediateData[5]}}, ImmediateData} : {2'b00, ImmediateData};

    int         checks = 0;
    int         failures = 0;
    logic       pfx_v;
    logic [1:0] pfx_b;
    logic [7:0] cnt_m;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_value(input logic [3:0] op, input logic [5:0] imm,
                                                input logic pv, input logic [1:0] pb);
        int v;
        v = imm;
        if (op == 4'h2 && imm >= 32) v = v + 192;
        if (pv) v = (v % 64) + pb * 64;
        return 8'(v);
    endfunction

    task automatic send(input logic [15:0] w);
        bit ok;
        ok = 0;
        InstrValid = 1'b1;
        Instr = w;
        for (int i = 0; i < 20; i++) begin
            if (InstrReady === 1'b1) begin ok = 1; break; end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_wait: InstrReady never rose for instr %h", w);
        end
        step();
        InstrValid = 1'b0;
    endtask

    task automatic run_load(input logic [3:0] op, input logic [2:0] rd, input logic [5:0] imm,
                            input int gnt);
        logic [7:0] exp_data;
        logic       exp_cs;
        bit         granted;
        exp_cs   = (op == 4'h2);
        exp_data = model_value(op, imm, pfx_v, pfx_b);
        pfx_v    = 1'b0;
        granted  = 0;
        send({op, rd, 3'($urandom), imm});
        checks++;
        if (CS !== exp_cs || ImmediateData !== imm || Busy !== 1'b1 || RegWrReq !== 1'b0) begin
            failures++;
            $display("FAIL ext: CS=%b imm=%h busy=%b req=%b, want CS=%b imm=%h busy=1 req=0",
                     CS, ImmediateData, Busy, RegWrReq, exp_cs, imm);
        end
        step();
        for (int k = 1; k <= TMO + 3; k++) begin
            checks++;
            if (RegWrReq !== 1'b1 || RegWrAddr !== rd || RegWrData !== exp_data || CS !== 1'b0) begin
                failures++;
                $display("FAIL wb%0d: req=%b addr=%0d data=%h cs=%b, want req=1 addr=%0d data=%h cs=0",
                         k, RegWrReq, RegWrAddr, RegWrData, CS, rd, exp_data);
            end
            RegWrGnt = (k == gnt);
            step();
            RegWrGnt = 1'b0;
            if (k == gnt) begin granted = 1; break; end
            if (k == TMO) break;
        end
        if (granted) cnt_m = cnt_m + 8'd1;
        checks++;
        if (RegWrReq !== 1'b0 || InstrReady !== 1'b1 || Busy !== 1'b0 || WrTimeout !== !granted ||
            LoadCount !== cnt_m || RegWrData !== 8'h00 || RegWrAddr !== 3'd0) begin
            failures++;
            $display("FAIL done: req=%b rdy=%b busy=%b to=%b cnt=%0d data=%h, want req=0 rdy=1 busy=0 to=%b cnt=%0d data=00",
                     RegWrReq, InstrReady, Busy, WrTimeout, LoadCount, RegWrData, !granted, cnt_m);
        end
        if (!granted) begin
            step();
            checks++;
            if (WrTimeout !== 1'b0) begin
                failures++;
                $display("FAIL to_pulse: WrTimeout=%b want 0 one cycle later", WrTimeout);
            end
        end
    endtask

    task automatic ldih(input logic [5:0] imm);
        send({4'h3, 3'($urandom), 3'($urandom), imm});
        pfx_v = 1'b1;
        pfx_b = imm[1:0];
        checks++;
        if (Busy !== 1'b0 || InstrReady !== 1'b1 || IllegalOp !== 1'b0) begin
            failures++;
            $display("FAIL ldih: busy=%b rdy=%b ill=%b, want 0 1 0", Busy, InstrReady, IllegalOp);
        end
    endtask

    task automatic illegal(input logic [3:0] op);
        send({op, 12'($urandom)});
        pfx_v = 1'b0;
        checks++;
        if (IllegalOp !== 1'b1 || Busy !== 1'b0 || RegWrReq !== 1'b0) begin
            failures++;
            $display("FAIL illegal: ill=%b busy=%b req=%b, want 1 0 0", IllegalOp, Busy, RegWrReq);
        end
        step();
        checks++;
        if (IllegalOp !== 1'b0 || RegWrReq !== 1'b0) begin
            failures++;
            $display("FAIL illegal_pulse: ill=%b req=%b, want 0 0", IllegalOp, RegWrReq);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        pfx_v = 1'b0;
        cnt_m = 8'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (InstrReady !== 1'b1 || Busy !== 1'b0 || CS !== 1'b0 || ImmediateData !== 6'd0 ||
            RegWrReq !== 1'b0 || RegWrAddr !== 3'd0 || RegWrData !== 8'd0 || IllegalOp !== 1'b0 ||
            WrTimeout !== 1'b0 || LoadCount !== 8'd0) begin
            failures++;
            $display("FAIL reset: rdy=%b busy=%b cs=%b imm=%h req=%b addr=%0d data=%h ill=%b to=%b cnt=%0d",
                     InstrReady, Busy, CS, ImmediateData, RegWrReq, RegWrAddr, RegWrData,
                     IllegalOp, WrTimeout, LoadCount);
        end
    endtask

    task automatic test_basic();
        run_load(4'h1, 3'd3, 6'h25, 1);
        run_load(4'h2, 3'd1, 6'h3A, 1);
    endtask

    task automatic test_prefix();
        ldih(6'h02);
        run_load(4'h2, 3'd2, 6'h3F, 1);
        run_load(4'h1, 3'd2, 6'h3F, 1);
        ldih(6'h01);
        ldih(6'h3E);
        run_load(4'h1, 3'd6, 6'h05, 1);
    endtask

    task automatic test_timeout();
        run_load(4'h1, 3'd7, 6'h11, 0);
        run_load(4'h2, 3'd5, 6'h22, TMO);
        run_load(4'h1, 3'd4, 6'h33, TMO + 1);
    endtask

    task automatic test_reset_mid();
        send({4'h1, 3'd5, 3'd0, 6'h15});
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        pfx_v = 1'b0;
        cnt_m = 8'd0;
        checks++;
        if (RegWrReq !== 1'b0 || Busy !== 1'b0 || LoadCount !== 8'd0 || InstrReady !== 1'b1 ||
            WrTimeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: req=%b busy=%b cnt=%0d rdy=%b to=%b", RegWrReq, Busy,
                     LoadCount, InstrReady, WrTimeout);
        end
        step();
        checks++;
        if (WrTimeout !== 1'b0 || RegWrReq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_to: to=%b req=%b, want 0 0", WrTimeout, RegWrReq);
        end
        run_load(4'h1, 3'd4, 6'h3F, 1);
        ldih(6'h03);
        do_reset();
        run_load(4'h1, 3'd4, 6'h3F, 1);
    endtask

    task automatic test_illegal();
        ldih(6'h03);
        illegal(4'hF);
        run_load(4'h2, 3'd2, 6'h3F, 1);
        illegal(4'h0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] c0;
        c0 = cnt_m;
        InstrValid = 1'b1;
        Instr = {4'h1, 3'd1, 3'd0, 6'h0A};
        step();
        Instr = {4'h2, 3'd6, 3'd0, 6'h30};
        RegWrGnt = 1'b1;
        step();
        checks++;
        if (InstrReady !== 1'b0 || RegWrReq !== 1'b1 || RegWrData !== 8'h0A) begin
            failures++;
            $display("FAIL b2b_wb1: rdy=%b req=%b data=%h, want 0 1 0a", InstrReady, RegWrReq, RegWrData);
        end
        step();
        checks++;
        if (InstrReady !== 1'b1 || LoadCount !== c0 + 8'd1 || RegWrReq !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: rdy=%b cnt=%0d req=%b, want 1 %0d 0", InstrReady, LoadCount,
                     RegWrReq, c0 + 8'd1);
        end
        step();
        InstrValid = 1'b0;
        checks++;
        if (CS !== 1'b1 || ImmediateData !== 6'h30 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ext2: cs=%b imm=%h busy=%b, want 1 30 1", CS, ImmediateData, Busy);
        end
        step();
        checks++;
        if (RegWrReq !== 1'b1 || RegWrAddr !== 3'd6 || RegWrData !== 8'hF0) begin
            failures++;
            $display("FAIL b2b_wb2: req=%b addr=%0d data=%h, want 1 6 f0", RegWrReq, RegWrAddr, RegWrData);
        end
        step();
        RegWrGnt = 1'b0;
        cnt_m = c0 + 8'd2;
        checks++;
        if (LoadCount !== cnt_m || Busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: cnt=%0d busy=%b, want %0d 0", LoadCount, Busy, cnt_m);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [6];
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = ops[$urandom_range(0, 5)];
            if (op == 4'h1 || op == 4'h2)
                run_load(op, 3'($urandom), 6'($urandom), $urandom_range(0, TMO + 2));
            else if (op == 4'h3)
                ldih(6'($urandom));
            else
                illegal(op);
        end
    endtask

    initial begin
        reset = 1'b1;
        InstrValid = 1'b0;
        Instr = 16'h0000;
        RegWrGnt = 1'b0;
        pfx_v = 1'b0;
        pfx_b = 2'b00;
        cnt_m = 8'd0;
        test_reset();
        test_basic();
        test_prefix();
        test_timeout();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
